// File: rtl/scoreboard_pkg.sv
// Shared types and default timing for the scoreboard pushbutton processors.
package scoreboard_pkg;

    // Per-channel press classifier states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        LONG  = 2'd2
    } pb_state_t;

    // Default timing, in clock cycles of a 1 kHz system clock
    localparam int PB_DEBOUNCE_TICKS = 20;
    localparam int PB_LONG_TICKS     = 1500;
    localparam int PB_REPEAT_TICKS   = 250;

endpackage

// File: rtl/pb_channel.sv
// One pushbutton channel: 2-FF synchroniser, debouncer and short/long/repeat classifier.
module pb_channel
    import scoreboard_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = PB_DEBOUNCE_TICKS,
    parameter int LONG_TICKS     = PB_LONG_TICKS,
    parameter int REPEAT_TICKS   = PB_REPEAT_TICKS,
    parameter bit REPEAT_EN      = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic pressed_o,
    output logic short_o,
    output logic long_o,
    output logic repeat_o
);

    localparam int DB_W   = $clog2(DEBOUNCE_TICKS + 1);
    localparam int HOLD_W = $clog2(LONG_TICKS + 1);
    localparam int REP_W  = $clog2(REPEAT_TICKS + 1);

    logic              sync_1;
    logic              sync_2;
    logic              db_level;
    logic [DB_W-1:0]   db_cnt;
    logic              db_mismatch;
    logic              db_done;
    logic              db_rise;

    pb_state_t         state;
    pb_state_t         state_next;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_next;
    logic [REP_W-1:0]  rep_cnt;
    logic [REP_W-1:0]  rep_next;
    logic              short_next;
    logic              long_next;
    logic              repeat_next;

    // Two-flop synchroniser for the asynchronous pin
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= btn_i;
            sync_2 <= sync_1;
        end
    end

    assign db_mismatch = (sync_2 != db_level);
    assign db_done     = db_mismatch && (db_cnt == DB_W'(DEBOUNCE_TICKS - 1));
    // Debounced level goes high on this edge; lets the FSM start counting in step with pressed_o
    assign db_rise     = db_done && !db_level;

    // Debouncer: level follows sync only after DEBOUNCE_TICKS consecutive mismatches
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            db_level <= 1'b0;
            db_cnt   <= '0;
        end else if (db_mismatch) begin
            if (db_done) begin
                db_level <= ~db_level;
                db_cnt   <= '0;
            end else begin
                db_cnt   <= db_cnt + DB_W'(1);
            end
        end else begin
            db_cnt <= '0;
        end
    end

    // Classifier state, counters and registered event pulses
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= IDLE;
            hold_cnt <= '0;
            rep_cnt  <= '0;
            short_o  <= 1'b0;
            long_o   <= 1'b0;
            repeat_o <= 1'b0;
        end else begin
            state    <= state_next;
            hold_cnt <= hold_next;
            rep_cnt  <= rep_next;
            short_o  <= short_next;
            long_o   <= long_next;
            repeat_o <= repeat_next;
        end
    end

    // Next-state and event logic; a release always beats reaching the long threshold
    always_comb begin
        state_next  = state;
        hold_next   = hold_cnt;
        rep_next    = rep_cnt;
        short_next  = 1'b0;
        long_next   = 1'b0;
        repeat_next = 1'b0;
        case (state)
            IDLE: begin
                if (db_rise) begin
                    state_next = PRESS;
                    hold_next  = '0;
                end
            end
            PRESS: begin
                if (!db_level) begin
                    short_next = 1'b1;
                    // A new rise can coincide with the release being seen when debounce is short
                    state_next = db_rise ? PRESS : IDLE;
                    hold_next  = '0;
                end else if (hold_cnt == HOLD_W'(LONG_TICKS - 1)) begin
                    long_next  = 1'b1;
                    rep_next   = '0;
                    state_next = LONG;
                end else begin
                    hold_next  = hold_cnt + HOLD_W'(1);
                end
            end
            LONG: begin
                if (!db_level) begin
                    state_next = db_rise ? PRESS : IDLE;
                    hold_next  = '0;
                end else if (REPEAT_EN) begin
                    if (rep_cnt == REP_W'(REPEAT_TICKS - 1)) begin
                        repeat_next = 1'b1;
                        rep_next    = '0;
                    end else begin
                        rep_next    = rep_cnt + REP_W'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
                hold_next  = '0;
                rep_next   = '0;
            end
        endcase
    end

    assign pressed_o = db_level;

endmodule

// File: rtl/pushbutton_processor_v2.sv
// Multi-channel pushbutton processor: one independent pb_channel per button.
module pushbutton_processor_v2
    import scoreboard_pkg::*;
#(
    parameter int NUM_BTN        = 2,
    parameter int DEBOUNCE_TICKS = PB_DEBOUNCE_TICKS,
    parameter int LONG_TICKS     = PB_LONG_TICKS,
    parameter int REPEAT_TICKS   = PB_REPEAT_TICKS,
    parameter bit REPEAT_EN      = 1'b1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NUM_BTN-1:0] btn_i,
    output logic [NUM_BTN-1:0] pressed_o,
    output logic [NUM_BTN-1:0] short_o,
    output logic [NUM_BTN-1:0] long_o,
    output logic [NUM_BTN-1:0] repeat_o
);

    // Parameter sanity, reported at elaboration
    if (NUM_BTN < 1) begin : g_bad_num_btn
        $error("NUM_BTN must be >= 1");
    end
    if (DEBOUNCE_TICKS < 1) begin : g_bad_debounce
        $error("DEBOUNCE_TICKS must be >= 1");
    end
    if (LONG_TICKS <= DEBOUNCE_TICKS) begin : g_bad_long
        $error("LONG_TICKS must exceed DEBOUNCE_TICKS");
    end
    if (REPEAT_TICKS < 1) begin : g_bad_repeat
        $error("REPEAT_TICKS must be >= 1");
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        pb_channel #(
            .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
            .LONG_TICKS     (LONG_TICKS),
            .REPEAT_TICKS   (REPEAT_TICKS),
            .REPEAT_EN      (REPEAT_EN)
        ) u_ch (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .btn_i     (btn_i[i]),
            .pressed_o (pressed_o[i]),
            .short_o   (short_o[i]),
            .long_o    (long_o[i]),
            .repeat_o  (repeat_o[i])
        );
    end

endmodule
